pcie_cpld_gen: RTL

PCIE_CPLD_GEN -- requirements
Module: pcie_cpld_gen

---
 rtl/pcie_cpld_gen_pkg.sv | 47 ++++
 rtl/pcie_cpld_gen_be_decode.sv | 30 +++
 rtl/pcie_cpld_gen.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pcie_cpld_gen_pkg.sv
// Shared PCIe packet definitions: completion status codes, TLP type constants,
// the 3-DW completion header layout and the completion generator FSM states.
package pcie_cpld_gen_pkg;

  typedef enum logic [2:0] {
    CPL_SC = 3'b000,
    CPL_UR = 3'b001,
    CPL_CA = 3'b100
  } cpl_status_e;

  localparam logic [4:0] CPL_TYPE = 5'b01010;
  localparam logic [2:0] FMT_CPL  = 3'b000;
  localparam logic [2:0] FMT_CPLD = 3'b010;

  // Field order is MSB first, so DW2 leads and DW0 lands in bits [31:0]
  typedef struct packed {
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic        rsvd_dw2;
    logic [6:0]  lo_addr;
    logic [15:0] cpl_id;
    cpl_status_e status;
    logic        bcm;
    logic [11:0] byte_count;
    logic [2:0]  fmt;
    logic [4:0]  tlp_type;
    logic        rsvd_dw0a;
    logic [2:0]  tc;
    logic        rsvd_dw0b;
    logic        attr_hi;
    logic        rsvd_dw0c;
    logic        th;
    logic        td;
    logic        ep;
    logic [1:0]  attr_lo;
    logic [1:0]  at;
    logic [9:0]  length;
  } cpl_hdr_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    TX
  } cpl_state_e;

endpackage

// File: rtl/pcie_cpld_gen_be_decode.sv
// First-DW byte-enable decoder: yields the completion byte count and the two
// low bits of the lower address for a single-DW read.
module pcie_be_decode (
  input  logic [3:0] first_be,
  output logic [2:0] byte_count,
  output logic [1:0] lo_addr_lsb
);

  always_comb begin
    byte_count = 3'd1;
    casez (first_be)
      4'b1??1:                     byte_count = 3'd4;
      4'b01?1, 4'b1?10:            byte_count = 3'd3;
      4'b0011, 4'b0110, 4'b1100:   byte_count = 3'd2;
      default:                     byte_count = 3'd1;
    endcase
  end

  always_comb begin
    lo_addr_lsb = 2'b00;
    casez (first_be)
      4'b???1, 4'b0000: lo_addr_lsb = 2'b00;
      4'b??10:          lo_addr_lsb = 2'b01;
      4'b?100:          lo_addr_lsb = 2'b10;
      4'b1000:          lo_addr_lsb = 2'b11;
      default:          lo_addr_lsb = 2'b00;
    endcase
  end

endmodule

// File: rtl/pcie_cpld_gen.sv
// Single-DW MRd completer: reads one DW over a pipelined read master and returns a
// one-beat CplD, or a UR Cpl for multi-DW requests. Define PCIE_CPLD_GEN_TIMEOUT_EN for a CA read timeout.
module pcie_cpld_gen
  import pcie_cpld_gen_pkg::*;
#(
  parameter int BAR_ADDR_W     = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [BAR_ADDR_W-1:0] req_addr,
  input  logic [9:0]            req_len,
  input  logic [3:0]            req_first_be,
  input  logic [15:0]           req_req_id,
  input  logic [7:0]            req_tag,
  input  logic [2:0]            req_tc,
  input  logic [2:0]            req_attr,
  input  logic [15:0]           cpl_id,
  output logic [BAR_ADDR_W-3:0] rd_address,
  output logic                  rd_read,
  input  logic                  rd_waitrequest,
  input  logic                  rd_readdatavalid,
  input  logic [31:0]           rd_readdata,
  output logic [255:0]          tx_data,
  output logic                  tx_valid,
  output logic                  tx_sop,
  output logic                  tx_eop,
  input  logic                  tx_ready,
  output logic [7:0]            stat_err_cnt
);

  cpl_state_e  state;
  logic [4:0]  l_addr_lo;
  logic [3:0]  l_be;
  logic [15:0] l_req_id;
  logic [7:0]  l_tag;
  logic [2:0]  l_tc;
  logic [2:0]  l_attr;
  logic        pending_err;

  logic        accept;
  logic        timeout_hit;
  logic [4:0]  src_addr_lo;
  logic [3:0]  src_be;
  logic [15:0] src_req_id;
  logic [7:0]  src_tag;
  logic [2:0]  src_tc;
  logic [2:0]  src_attr;
  logic [2:0]  be_bc;
  logic [1:0]  be_lo;
  cpl_status_e cur_status;
  cpl_hdr_t    hdr;
  logic [255:0] next_tx_data;
  logic        unused_addr_bits;

  assign unused_addr_bits = &{1'b0, req_addr[1:0]};
  assign accept = req_valid && req_ready;

  // The UR path builds its TLP in the accept cycle, before the fields are latched
  assign src_addr_lo = (state == IDLE) ? req_addr[6:2]  : l_addr_lo;
  assign src_be      = (state == IDLE) ? req_first_be   : l_be;
  assign src_req_id  = (state == IDLE) ? req_req_id     : l_req_id;
  assign src_tag     = (state == IDLE) ? req_tag        : l_tag;
  assign src_tc      = (state == IDLE) ? req_tc         : l_tc;
  assign src_attr    = (state == IDLE) ? req_attr       : l_attr;

  pcie_be_decode u_be_decode (
    .first_be    (src_be),
    .byte_count  (be_bc),
    .lo_addr_lsb (be_lo)
  );

`ifdef PCIE_CPLD_GEN_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n)
      tmo_cnt <= '0;
    else if (state == RD_ISSUE || state == RD_WAIT)
      tmo_cnt <= tmo_cnt + 1'b1;
    else
      tmo_cnt <= '0;
  end

  assign timeout_hit = (state == RD_ISSUE || state == RD_WAIT) &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    cur_status = CPL_CA;
    if (state == IDLE)
      cur_status = CPL_UR;
    else if (state == RD_WAIT && rd_readdatavalid)
      cur_status = CPL_SC;
  end

  always_comb begin
    hdr            = '0;
    hdr.fmt        = (cur_status == CPL_SC) ? FMT_CPLD : FMT_CPL;
    hdr.tlp_type   = CPL_TYPE;
    hdr.tc         = src_tc;
    hdr.attr_hi    = src_attr[2];
    hdr.attr_lo    = src_attr[1:0];
    hdr.length     = (cur_status == CPL_SC) ? 10'd1 : 10'd0;
    hdr.cpl_id     = cpl_id;
    hdr.status     = cur_status;
    hdr.bcm        = 1'b0;
    hdr.byte_count = (cur_status == CPL_UR) ? 12'd4 : {9'd0, be_bc};
    hdr.req_id     = src_req_id;
    hdr.tag        = src_tag;
    hdr.lo_addr    = {src_addr_lo, be_lo};
    next_tx_data        = '0;
    next_tx_data[95:0]  = hdr;
    if (cur_status == CPL_SC) begin
      if (src_addr_lo[0])
        next_tx_data[127:96]  = rd_readdata;
      else
        next_tx_data[159:128] = rd_readdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      rd_read      <= 1'b0;
      rd_address   <= '0;
      tx_valid     <= 1'b0;
      tx_sop       <= 1'b0;
      tx_eop       <= 1'b0;
      tx_data      <= '0;
      stat_err_cnt <= '0;
      pending_err  <= 1'b0;
      l_addr_lo    <= '0;
      l_be         <= '0;
      l_req_id     <= '0;
      l_tag        <= '0;
      l_tc         <= '0;
      l_attr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            l_addr_lo <= req_addr[6:2];
            l_be      <= req_first_be;
            l_req_id  <= req_req_id;
            l_tag     <= req_tag;
            l_tc      <= req_tc;
            l_attr    <= req_attr;
            if (req_len == 10'd1) begin
              state      <= RD_ISSUE;
              rd_read    <= 1'b1;
              rd_address <= req_addr[BAR_ADDR_W-1:2];
            end else begin
              state       <= TX;
              tx_valid    <= 1'b1;
              tx_sop      <= 1'b1;
              tx_eop      <= 1'b1;
              tx_data     <= next_tx_data;
              pending_err <= 1'b1;
            end
          end
        end
        RD_ISSUE: begin
          if (!rd_waitrequest) begin
            rd_read <= 1'b0;
            state   <= RD_WAIT;
          end
          if (timeout_hit) begin
            rd_read     <= 1'b0;
            state       <= TX;
            tx_valid    <= 1'b1;
            tx_sop      <= 1'b1;
            tx_eop      <= 1'b1;
            tx_data     <= next_tx_data;
            pending_err <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (rd_readdatavalid || timeout_hit) begin
            state       <= TX;
            tx_valid    <= 1'b1;
            tx_sop      <= 1'b1;
            tx_eop      <= 1'b1;
            tx_data     <= next_tx_data;
            pending_err <= (cur_status != CPL_SC);
          end
        end
        TX: begin
          if (tx_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            tx_valid  <= 1'b0;
            tx_sop    <= 1'b0;
            tx_eop    <= 1'b0;
            tx_data   <= '0;
            if (pending_err && stat_err_cnt != 8'hFF)
              stat_err_cnt <= stat_err_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
